md_hilo_unit: RTL and testbench

- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of instruction decode. It consumes the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO decode bits plus the forwarded operands.
- Multiply is single-cycle. Division is a 32-iteration restoring FSM that stalls the pipeline through md_stall.
- HI/LO reads and writes are serialised against an in-flight division.

---
 rtl/md_hilo_unit.sv | 99 +++++++++
 tb/tb_md_hilo_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_unit.sv
// md_hilo_unit: EX-stage multiply/divide unit with HI/LO registers and a 32-step restoring divider.
// Optional MADD/MADDU/MSUB/MSUBU accumulate path enabled by defining MD_MADD_EN.
module md_hilo_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid,
  input  logic [11:0] md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        md_stall,
  output logic [31:0] md_result,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_done
);
  localparam int CW = $clog2(DIV_ITERS);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;
  logic [31:0] hi, lo, rem, quo, dvs, abs_a, abs_b;
  logic [CW-1:0] cnt;
  logic sa, sb, one_hot, accept, is_div;
  logic [32:0] trial;
  logic [63:0] prod_s, prod_u;
  always_comb begin
    one_hot = (md_op != '0) && ((md_op & (md_op - 12'd1)) == '0);
    accept = md_valid && !flush && state == IDLE && one_hot;
    is_div = md_op[9] || md_op[8];
    md_stall = !rst && !flush && (state == RUN || state == FIX || (accept && is_div));
    div_done = !rst && !flush && state == FIX;
    md_result = state != IDLE ? '0 : md_op == 12'h080 ? hi : md_op == 12'h040 ? lo : '0;
    abs_a = md_op[9] && src_a[31] ? -src_a : src_a;
    abs_b = md_op[9] && src_b[31] ? -src_b : src_b;
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    // Borrow out of the 33-bit trial subtract means the divisor did not fit.
    trial = {rem, quo[31]} - {1'b0, dvs};
  end
`ifdef MD_MADD_EN
  logic [63:0] mac_prod, mac_res;
  always_comb begin
    mac_prod = (md_op[3] || md_op[1]) ? prod_s : prod_u;
    mac_res = (md_op[3] || md_op[2]) ? {hi, lo} + mac_prod : {hi, lo} - mac_prod;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (md_op[11]) {hi, lo} <= prod_s;
          else if (md_op[10]) {hi, lo} <= prod_u;
          else if (md_op[5]) hi <= src_a;
          else if (md_op[4]) lo <= src_a;
          else if (is_div) begin
            rem <= '0;
            quo <= abs_a;
            dvs <= abs_b;
            sa <= md_op[9] && src_a[31];
            sb <= md_op[9] && src_b[31];
            cnt <= CW'(DIV_ITERS - 1);
            state <= RUN;
          end
`ifdef MD_MADD_EN
          else if (|md_op[3:0]) {hi, lo} <= mac_res;
`endif
        end
        RUN: begin
          rem <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
          quo <= {quo[30:0], ~trial[32]};
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo <= (sa ^ sb) ? -quo : quo;
          hi <= sa ? -rem : rem;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign hi_out = hi;
  assign lo_out = lo;
endmodule

// File: tb/tb_md_hilo_unit.sv
// tb_md_hilo_unit: scoreboard bench for md_hilo_unit against an arithmetic HI:LO model.
module tb_md_hilo_unit;
  localparam logic [11:0] OP_MULT = 12'h800, OP_MULTU = 12'h400, OP_DIV = 12'h200, OP_DIVU = 12'h100;
  localparam logic [11:0] OP_MFHI = 12'h080, OP_MFLO = 12'h040, OP_MTHI = 12'h020, OP_MTLO = 12'h010;
  localparam logic [11:0] OP_MADD = 12'h008, OP_MADDU = 12'h004, OP_MSUB = 12'h002, OP_MSUBU = 12'h001;
  logic clk = 1'b0, rst, md_valid, flush, md_stall, div_done;
  logic [11:0] md_op;
  logic [31:0] src_a, src_b, md_result, hi_out, lo_out;
  typedef struct {logic [31:0] res, hi, lo;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0, exp_done = 0, got_done = 0;
  logic [63:0] m_hl = '0;
  logic pend = 1'b0;
  logic [31:0] res_cap;

  md_hilo_unit #(.DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .md_stall(md_stall), .md_result(md_result), .hi_out(hi_out), .lo_out(lo_out),
    .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an instruction retires when it is valid, unflushed and unstalled; its
  // result is captured then and HI/LO are compared one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'(sbq.size()), 32'd1);
      else begin
        mon_e = sbq.pop_front();
        chk("result", res_cap, mon_e.res);
        chk("hi", hi_out, mon_e.hi);
        chk("lo", lo_out, mon_e.lo);
      end
      pend = 1'b0;
    end
    if (!rst && div_done) got_done++;
    if (!rst && md_valid && md_op != '0 && (md_op & (md_op - 12'd1)) != '0)
      $display("note: multi-bit md_op %h treated as no-op", md_op);
    if (!rst && md_valid && !flush && !md_stall) begin
      pend = 1'b1;
      res_cap = md_result;
    end
  end

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int stalls = 0, exp_st = 0;
    logic [31:0] ua, ub, q, r;
    logic ng_a, ng_b;
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    e.res = '0;
    case (op)
      OP_MULT: m_hl = 64'(p);
      OP_MULTU: m_hl = {32'd0, a} * {32'd0, b};
      OP_MTHI: m_hl[63:32] = a;
      OP_MTLO: m_hl[31:0] = a;
      OP_MFHI: e.res = m_hl[63:32];
      OP_MFLO: e.res = m_hl[31:0];
      OP_DIV, OP_DIVU: begin
        ng_a = op == OP_DIV && a[31];
        ng_b = op == OP_DIV && b[31];
        ua = ng_a ? -a : a;
        ub = ng_b ? -b : b;
        q = ub == 0 ? 32'hFFFF_FFFF : ua / ub;
        r = ub == 0 ? ua : ua % ub;
        if (ng_a ^ ng_b) q = -q;
        if (ng_a) r = -r;
        m_hl = {r, q};
        exp_st = 34;
        exp_done++;
      end
`ifdef MD_MADD_EN
      OP_MADD: m_hl = m_hl + 64'(p);
      OP_MADDU: m_hl = m_hl + {32'd0, a} * {32'd0, b};
      OP_MSUB: m_hl = m_hl - 64'(p);
      OP_MSUBU: m_hl = m_hl - {32'd0, a} * {32'd0, b};
`endif
      default: ;
    endcase
    e.hi = m_hl[63:32];
    e.lo = m_hl[31:0];
    sbq.push_back(e);
    md_valid = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    forever begin
      @(negedge clk);
      if (!md_stall) break;
      stalls++;
      if (stalls > 100) begin
        chk("stall_timeout", 32'(stalls), 32'(exp_st));
        break;
      end
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_st));
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    md_op = 12'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  initial begin
    logic [11:0] op;
    int k;
    rst = 1'b1; flush = 1'b0; md_valid = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_stall", 32'(md_stall), 32'd0);
    chk("rst_done", 32'(div_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFA);
    issue(OP_DIVU, 32'd100, 32'd7);
    chk("divu_lo", lo_out, 32'd14);
    chk("divu_hi", hi_out, 32'd2);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_out, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", lo_out, 32'h8000_0000);
    chk("div_ovf_hi", hi_out, 32'd0);
    issue(OP_DIVU, 32'h1234_5678, 32'd0);
    chk("div0_lo", lo_out, 32'hFFFF_FFFF);
    chk("div0_hi", hi_out, 32'h1234_5678);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    issue(OP_MTHI, 32'hAAAA_0000, $urandom);
    // Flush a division partway through RUN: nothing retires, HI/LO untouched.
    md_valid = 1'b1; md_op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(md_stall), 32'd0);
    chk("flush_done", 32'(div_done), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; md_valid = 1'b0;
    @(negedge clk);
    chk("flush_hi", hi_out, 32'hAAAA_0000);
    @(posedge clk);
    #1;
    issue(OP_MFHI, $urandom, $urandom);
`ifdef MD_MADD_EN
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'h10, 32'd0);
    issue(OP_MSUBU, 32'd2, 32'd8);
    chk("msubu_hi", hi_out, 32'd0);
    chk("msubu_lo", lo_out, 32'd0);
    issue(OP_MADD, 32'hFFFF_FFFF, 32'd1);
    chk("madd_hi", hi_out, 32'hFFFF_FFFF);
    chk("madd_lo", lo_out, 32'hFFFF_FFFF);
`endif
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 13);
      if (k == 13) begin
        md_valid = 1'b0;
        md_op = 12'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else begin
        op = k == 12 ? (OP_MULT | OP_MTHI) : 12'h001 << k;
        issue(op, rnd(), rnd());
      end
    end
    repeat (3) @(negedge clk);
    chk("div_done_count", 32'(got_done), 32'(exp_done));
    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
